// File: rtl/sif_wa_write_buffer.sv
// In-order write buffer between the SIF W-side write stream and a slower req/ack memory port.
// Reports fill level, an advisory full flag and a sticky overflow flag.
module sif_wa_write_buffer #(
   parameter int DEPTH = 8,
   parameter int AW    = 16,
   parameter int DW    = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         wa_wr_s,
   input  logic [AW-1:0]                wa_addr,
   input  logic [DW-1:0]                wa_data_wr,
   output logic                         wa_full,
   output logic                         mem_req,
   output logic [AW-1:0]                mem_addr,
   output logic [DW-1:0]                mem_data,
   input  logic                         mem_ack,
   output logic [$clog2(DEPTH+1)-1:0]   fill_level,
   output logic                         ovf_err,
   input  logic                         ovf_clr
);

   localparam int PW = $clog2(DEPTH);
   localparam int FW = $clog2(DEPTH+1);

   typedef enum logic {IDLE, REQ} state_t;

   logic [AW+DW-1:0] fifo_q [DEPTH];
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, rd_ptr_nx;
   logic [FW-1:0]    fill_q, fill_d;
   state_t           state_q;
   logic             mem_req_q, full_q, ovf_q;
   logic [AW-1:0]    mem_addr_q;
   logic [DW-1:0]    mem_data_q;
   logic             push, pop, drop;
   logic [AW+DW-1:0] head_entry, next_entry;

   // A write into a full buffer still fits when the head leaves on the same edge.
   always_comb begin
      pop       = mem_req_q & mem_ack;
      push      = wa_wr_s & ((fill_q != FW'(DEPTH)) | pop);
      drop      = wa_wr_s & ~push;
      rd_ptr_nx = rd_ptr_q + PW'(1);
      rd_ptr_d  = pop  ? rd_ptr_nx : rd_ptr_q;
      wr_ptr_d  = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      fill_d    = fill_q;
      if (push && !pop) begin
         fill_d = fill_q + FW'(1);
      end else if (pop && !push) begin
         fill_d = fill_q - FW'(1);
      end
      head_entry = fifo_q[rd_ptr_q];
      next_entry = fifo_q[rd_ptr_nx];
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_q[wr_ptr_q] <= {wa_addr, wa_data_wr};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         fill_q     <= '0;
         full_q     <= 1'b0;
         ovf_q      <= 1'b0;
         mem_req_q  <= 1'b0;
         mem_addr_q <= '0;
         mem_data_q <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         fill_q   <= fill_d;
         full_q   <= (fill_d == FW'(DEPTH));
         if (drop) begin
            ovf_q <= 1'b1;
         end else if (ovf_clr) begin
            ovf_q <= 1'b0;
         end
         case (state_q)
            IDLE: begin
               if (fill_q != '0) begin
                  {mem_addr_q, mem_data_q} <= head_entry;
                  mem_req_q <= 1'b1;
                  state_q   <= REQ;
               end
            end
            REQ: begin
               // Last entry acked: drop req for one cycle even if a new write lands now.
               if (mem_ack) begin
                  if (fill_q > FW'(1)) begin
                     {mem_addr_q, mem_data_q} <= next_entry;
                  end else begin
                     mem_req_q <= 1'b0;
                     state_q   <= IDLE;
                  end
               end
            end
            default: begin
               state_q   <= IDLE;
               mem_req_q <= 1'b0;
            end
         endcase
      end
   end

   assign wa_full    = full_q;
   assign mem_req    = mem_req_q;
   assign mem_addr   = mem_addr_q;
   assign mem_data   = mem_data_q;
   assign fill_level = fill_q;
   assign ovf_err    = ovf_q;

endmodule

// File: tb/tb_sif_wa_write_buffer.sv
// Directed bench for sif_wa_write_buffer: vector table plus hand-written multi-cycle sequences.
module tb_sif_wa_write_buffer;

   logic        clk = 1'b0;
   logic        rst_n, wa_wr_s, mem_ack, ovf_clr;
   logic [15:0] wa_addr, wa_data_wr;
   logic        wa_full, mem_req, ovf_err;
   logic [15:0] mem_addr, mem_data;
   logic [3:0]  fill_level;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   sif_wa_write_buffer #(.DEPTH(8), .AW(16), .DW(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .wa_wr_s    (wa_wr_s),
      .wa_addr    (wa_addr),
      .wa_data_wr (wa_data_wr),
      .wa_full    (wa_full),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_data   (mem_data),
      .mem_ack    (mem_ack),
      .fill_level (fill_level),
      .ovf_err    (ovf_err),
      .ovf_clr    (ovf_clr)
   );

   typedef struct {
      logic        rst_n, wr, ack, clr;
      logic [15:0] addr, data;
      logic        exp_req;
      logic [15:0] exp_addr, exp_data;
      logic [3:0]  exp_fill;
      logic        exp_full, exp_ovf;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic step(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d,
                       input logic k, input logic c);
      rst_n = r; wa_wr_s = w; wa_addr = a; wa_data_wr = d; mem_ack = k; ovf_clr = c;
      @(posedge clk);
      #1;
      $display("step t=%0t rst_n=%b wr=%b addr=%h data=%h ack=%b clr=%b -> req=%b maddr=%h mdata=%h fill=%0d full=%b ovf=%b",
               $time, r, w, a, d, k, c, mem_req, mem_addr, mem_data, fill_level, wa_full, ovf_err);
   endtask

   task automatic expect_out(input string name, input logic req, input logic [15:0] a,
                             input logic [15:0] d, input logic [3:0] fill, input logic full,
                             input logic ovf);
      chk({name, ".mem_req"}, 32'(mem_req), 32'(req));
      if (req) begin
         chk({name, ".mem_addr"}, 32'(mem_addr), 32'(a));
         chk({name, ".mem_data"}, 32'(mem_data), 32'(d));
      end
      chk({name, ".fill_level"}, 32'(fill_level), 32'(fill));
      chk({name, ".wa_full"}, 32'(wa_full), 32'(full));
      chk({name, ".ovf_err"}, 32'(ovf_err), 32'(ovf));
   endtask

   logic [15:0] exp_a [8];
   logic [15:0] exp_d [8];

   initial begin
      rst_n = 1'b0; wa_wr_s = 1'b0; wa_addr = '0; wa_data_wr = '0; mem_ack = 1'b0; ovf_clr = 1'b0;

      // rst_n wr ack clr addr data | req addr data fill full ovf
      vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0};
      vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0};
      vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h1234, 16'hABCD, 1'b0, 16'h0000, 16'h0000, 4'd1, 1'b0, 1'b0};
      vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h1234, 16'hABCD, 4'd1, 1'b0, 1'b0};
      vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0};
      vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0};

      for (int i = 0; i < 6; i++) begin
         step(vecs[i].rst_n, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].ack, vecs[i].clr);
         expect_out($sformatf("vec%0d", i), vecs[i].exp_req, vecs[i].exp_addr, vecs[i].exp_data,
                    vecs[i].exp_fill, vecs[i].exp_full, vecs[i].exp_ovf);
      end

      // Fill to capacity with no acks; entry 0 is presented from the second write on.
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 1'b1, 16'(i), 16'hA0 + 16'(i), 1'b0, 1'b0);
         expect_out($sformatf("fill%0d", i), (i > 0), 16'h0000, 16'h00A0, 4'(i + 1), (i == 7), 1'b0);
      end
      step(1'b1, 1'b1, 16'hDEAD, 16'hDEAD, 1'b0, 1'b0);
      expect_out("drop9", 1'b1, 16'h0000, 16'h00A0, 4'd8, 1'b1, 1'b1);

      step(1'b1, 1'b1, 16'hDEAD, 16'hBEEF, 1'b0, 1'b1);
      expect_out("clr_with_drop", 1'b1, 16'h0000, 16'h00A0, 4'd8, 1'b1, 1'b1);

      step(1'b1, 1'b1, 16'h0100, 16'hB000, 1'b1, 1'b0);
      expect_out("full_push_pop", 1'b1, 16'h0001, 16'h00A1, 4'd8, 1'b1, 1'b1);

      step(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
      expect_out("clr_alone", 1'b1, 16'h0001, 16'h00A1, 4'd8, 1'b1, 1'b0);

      for (int j = 0; j < 8; j++) begin
         exp_a[j] = (j < 7) ? 16'(j + 1) : 16'h0100;
         exp_d[j] = (j < 7) ? 16'hA1 + 16'(j) : 16'hB000;
      end
      for (int j = 0; j < 8; j++) begin
         step(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
         if (j < 7)
            expect_out($sformatf("drain%0d", j), 1'b1, exp_a[j + 1], exp_d[j + 1], 4'(7 - j), 1'b0, 1'b0);
         else
            expect_out("drain_end", 1'b0, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0);
      end

      // Single entry held without ack: request must stay frozen.
      step(1'b1, 1'b1, 16'h55AA, 16'h1357, 1'b0, 1'b0);
      expect_out("hold_wr", 1'b0, 16'h0000, 16'h0000, 4'd1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
      expect_out("hold_req", 1'b1, 16'h55AA, 16'h1357, 4'd1, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
         expect_out($sformatf("hold%0d", i), 1'b1, 16'h55AA, 16'h1357, 4'd1, 1'b0, 1'b0);
      end
      step(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
      expect_out("hold_ack", 1'b0, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0);

      // Reset in the middle of a 4-entry drain.
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b1, 16'h0010 + 16'(i), 16'h00C0 + 16'(i), 1'b0, 1'b0);
         expect_out($sformatf("rfill%0d", i), (i > 0), 16'h0010, 16'h00C0, 4'(i + 1), 1'b0, 1'b0);
      end
      step(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
      expect_out("rdrain0", 1'b1, 16'h0011, 16'h00C1, 4'd3, 1'b0, 1'b0);
      step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
      expect_out("rst_mid", 1'b0, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0);
      chk("rst_mid.mem_addr", 32'(mem_addr), 32'h0);
      chk("rst_mid.mem_data", 32'(mem_data), 32'h0);
      step(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
      expect_out("post_rst", 1'b0, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
